// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   arb_state_e  - arbiter FSM states (no owner / owner active)
//   ARB_MAX_N    - largest supported requester count
//   ARB_HOLD_W   - width of the optional hold-limit counter
package arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam int ARB_MAX_N  = 32;
   localparam int ARB_HOLD_W = 8;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Circular first-set-bit picker: scans from a start index, wrapping mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is always valid for the current inputs.
//
// Ports:
//   i_req   [N-1:0]   candidate request vector
//   i_start [IDW-1:0] index searched first (must be < N)
//   i_excl  [N-1:0]   requesters removed from this search
//   o_gnt   [N-1:0]   one-hot winner, zero when nothing is eligible
//   o_idx   [IDW-1:0] winner index, zero when nothing is eligible
//   o_found           high when a winner exists
module rr_pick #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_start,
   input  logic [N-1:0]   i_excl,
   output logic [N-1:0]   o_gnt,
   output logic [IDW-1:0] o_idx,
   output logic           o_found
);

   logic [N-1:0] w_masked;

   assign w_masked = i_req & ~i_excl;

   always_comb begin
      int j;
      j       = 0;
      o_gnt   = '0;
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         // Offset from the start pointer, folded back into 0..N-1 so a
         // non-power-of-two N never produces an out-of-range index.
         j = int'(i_start) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!o_found && w_masked[j[IDW-1:0]]) begin
            o_found               = 1'b1;
            o_idx                 = j[IDW-1:0];
            o_gnt[j[IDW-1:0]]     = 1'b1;
         end
      end
   end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant and grant hold.
// Latency: req sampled at edge k drives gnt/gnt_id/busy right after edge k.
// Backpressure: owner keeps the grant while its req is high (bounded by MAX_HOLD if enabled).
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   req    [N-1:0]   level-sensitive request vector
//   gnt    [N-1:0]   registered one-hot grant, or zero
//   gnt_id [IDW-1:0] registered owner index; holds the last owner while idle
//   busy             registered, high iff gnt is non-zero
//
// Optional feature macro: RR_ARB_HOLD_LIMIT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles is
//   forced to release if any other requester is waiting.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 16,
   localparam int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy
);

   // Parameter range checks at elaboration.
   if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
      $error("rr_arbiter: N out of range 2..32");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter: MAX_HOLD out of range 1..255");
   end

   arb_state_e     r_state;
   arb_state_e     w_state_nxt;
   logic [N-1:0]   r_gnt;
   logic [N-1:0]   w_gnt_nxt;
   logic [IDW-1:0] r_gnt_id;
   logic [IDW-1:0] w_gnt_id_nxt;
   logic [IDW-1:0] r_last;
   logic [IDW-1:0] w_last_nxt;
   logic           r_busy;
   logic           w_new_grant;

   logic           w_owner_req;
   logic           w_force;
   logic [IDW-1:0] w_start;
   logic [N-1:0]   w_excl;
   logic [N-1:0]   w_pick_gnt;
   logic [IDW-1:0] w_pick_idx;
   logic           w_pick_found;

   // r_gnt is zero while idle, so this is only ever true for a live owner.
   assign w_owner_req = |(req & r_gnt);

   // Search begins one past the previous winner; explicit wrap keeps
   // the pointer inside 0..N-1 for non-power-of-two N.
   assign w_start = (r_last == IDW'(N - 1)) ? '0 : r_last + IDW'(1);

   // The owner is only removed from the search when it is being
   // pushed out, so a voluntary release still lets it re-win normally.
   assign w_excl = w_force ? r_gnt : '0;

`ifdef RR_ARB_HOLD_LIMIT_EN
   logic [ARB_HOLD_W-1:0] r_hold;
   logic [ARB_HOLD_W-1:0] w_hold_nxt;
   logic                  w_others;

   assign w_others = |(req & ~r_gnt);
   assign w_force  = (r_state == ARB_BUSY)
                   && (r_hold >= ARB_HOLD_W'(MAX_HOLD))
                   && w_others;

   always_comb begin
      w_hold_nxt = r_hold;
      if (w_new_grant) begin
         w_hold_nxt = ARB_HOLD_W'(1);
      end else if (w_state_nxt == ARB_BUSY) begin
         // Owner continues: count up and saturate at the limit.
         if (r_hold < ARB_HOLD_W'(MAX_HOLD)) begin
            w_hold_nxt = r_hold + ARB_HOLD_W'(1);
         end
      end else begin
         w_hold_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else begin
         r_hold <= w_hold_nxt;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   rr_pick #(
      .N (N)
   ) u_pick (
      .i_req   (req),
      .i_start (w_start),
      .i_excl  (w_excl),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_last_nxt   = r_last;
      w_new_grant  = 1'b0;
      unique case (r_state)
         ARB_IDLE: begin
            if (w_pick_found) begin
               w_state_nxt  = ARB_BUSY;
               w_gnt_nxt    = w_pick_gnt;
               w_gnt_id_nxt = w_pick_idx;
               w_last_nxt   = w_pick_idx;
               w_new_grant  = 1'b1;
            end
         end
         ARB_BUSY: begin
            if (!w_owner_req || w_force) begin
               // Handoff is back-to-back: the next owner is loaded on the
               // same edge the current owner loses its grant.
               if (w_pick_found) begin
                  w_gnt_nxt    = w_pick_gnt;
                  w_gnt_id_nxt = w_pick_idx;
                  w_last_nxt   = w_pick_idx;
                  w_new_grant  = 1'b1;
               end else begin
                  w_state_nxt = ARB_IDLE;
                  w_gnt_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ARB_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_last   <= IDW'(N - 1);
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_last   <= w_last_nxt;
         r_busy   <= |w_gnt_nxt;
      end
   end

   assign gnt    = r_gnt;
   assign gnt_id = r_gnt_id;
   assign busy   = r_busy;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed table, corner sequences, random vs model.
// Latency: expects outputs updated one edge after req is sampled.
// Backpressure: n/a (bench).
module tb_rr_arbiter;

`ifdef RR_ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif
   localparam int MH = 4;

   typedef struct {
      int owner;   // -1 when nobody holds the grant
      int last;    // most recent winner
      int id;      // reported owner index
      int cnt;     // consecutive cycles held by owner
   } model_t;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req4;
   logic [3:0] gnt4;
   logic [1:0] id4;
   logic       busy4;
   logic [2:0] req3;
   logic [2:0] gnt3;
   logic [1:0] id3;
   logic       busy3;

   int     checks = 0;
   int     errors = 0;
   model_t m4;
   model_t m3;

   always #5 clk = ~clk;

   rr_arbiter #(.N(4), .MAX_HOLD(MH)) dut4 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req4),
      .gnt    (gnt4),
      .gnt_id (id4),
      .busy   (busy4)
   );

   rr_arbiter #(.N(3), .MAX_HOLD(MH)) dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req3),
      .gnt    (gnt3),
      .gnt_id (id3),
      .busy   (busy3)
   );

   function automatic model_t mreset(input int n);
      model_t m;
      m.owner = -1;
      m.last  = n - 1;
      m.id    = 0;
      m.cnt   = 0;
      return m;
   endfunction

   // One clock edge of the arbitration rules, applied to a plain state record.
   function automatic model_t mstep(input model_t m_in, input int n, input logic [31:0] rq);
      model_t m;
      bit     others;
      bit     forced;
      int     c;
      m      = m_in;
      forced = 1'b0;
      if (m.owner >= 0 && rq[m.owner]) begin
         others = (rq & ~(32'd1 << m.owner)) != 32'd0;
         if (!(HOLD_EN && m.cnt >= MH && others)) begin
            if (m.cnt < MH) m.cnt++;
            return m;
         end
         forced = 1'b1;
      end
      for (int k = 1; k <= n; k++) begin
         c = (m.last + k) % n;
         if (rq[c] && !(forced && c == m.owner)) begin
            m.owner = c;
            m.last  = c;
            m.id    = c;
            m.cnt   = 1;
            return m;
         end
      end
      m.owner = -1;
      m.cnt   = 0;
      return m;
   endfunction

   function automatic logic [31:0] egnt(input model_t m);
      return (m.owner < 0) ? 32'd0 : (32'd1 << m.owner);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic [3:0] a, input logic [2:0] b);
      @(negedge clk);
      req4 = a;
      req3 = b;
      @(posedge clk);
      m4 = mstep(m4, 4, {28'd0, a});
      m3 = mstep(m3, 3, {29'd0, b});
      #1;
   endtask

   task automatic cmp_model();
      chk("gnt4_model",  32'(gnt4),  egnt(m4));
      chk("id4_model",   32'(id4),   32'(m4.id));
      chk("busy4_model", 32'(busy4), 32'(m4.owner >= 0));
      chk("gnt3_model",  32'(gnt3),  egnt(m3));
      chk("id3_model",   32'(id3),   32'(m3.id));
      chk("busy3_model", 32'(busy3), 32'(m3.owner >= 0));
      chk("gnt4_onehot0", 32'($onehot0(gnt4)), 32'd1);
      chk("gnt3_onehot0", 32'($onehot0(gnt3)), 32'd1);
      chk("busy4_eq_or",  32'(busy4 == (|gnt4)), 32'd1);
      chk("busy3_eq_or",  32'(busy3 == (|gnt3)), 32'd1);
      chk("gnt4_in_req",  32'(gnt4 & ~req4), 32'd0);
      chk("gnt3_in_req",  32'(gnt3 & ~req3), 32'd0);
      chk("id3_range",    32'(id3 < 2'd3), 32'd1);
   endtask

   initial begin
      vec_t       tbl[12];
      logic [3:0] r4;
      logic [2:0] r3;

      tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
      tbl[1]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
      tbl[2]  = '{4'b1100, 4'b0100, 2'd2, 1'b1};
      tbl[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
      tbl[4]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
      tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
      tbl[6]  = '{4'b0110, 4'b0010, 2'd1, 1'b1};
      tbl[7]  = '{4'b0110, 4'b0010, 2'd1, 1'b1};
      tbl[8]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
      tbl[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
      tbl[10] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
      tbl[11] = '{4'b0011, 4'b0001, 2'd0, 1'b1};

      rst_n = 1'b0;
      req4  = '0;
      req3  = '0;
      m4    = mreset(4);
      m3    = mreset(3);
      #12;
      chk("rst_gnt4",  32'(gnt4),  32'd0);
      chk("rst_id4",   32'(id4),   32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_gnt3",  32'(gnt3),  32'd0);
      chk("rst_busy3", 32'(busy3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed rotation / idle / handoff table.
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].req, 3'b000);
         chk($sformatf("tbl%0d_gnt", i),  32'(gnt4),  32'(tbl[i].gnt));
         chk($sformatf("tbl%0d_id", i),   32'(id4),   32'(tbl[i].id));
         chk($sformatf("tbl%0d_busy", i), 32'(busy4), 32'(tbl[i].busy));
         cmp_model();
      end

      // Grant hold (or forced rotation when the hold limit is built in).
      cycle(4'b0000, 3'b000);
      cycle(4'b0100, 3'b000);
      chk("hold_start_gnt", 32'(gnt4), 32'h4);
`ifndef RR_ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 40; i++) begin
         cycle(4'b0110, 3'b000);
         chk("hold40_gnt", 32'(gnt4), 32'h4);
      end
      cycle(4'b0010, 3'b000);
      chk("handoff_gnt",  32'(gnt4),  32'h2);
      chk("handoff_busy", 32'(busy4), 32'd1);
`else
      begin
         int run;
         logic [3:0] prev;
         run  = 0;
         prev = gnt4;
         for (int i = 0; i < 24; i++) begin
            cycle(4'b0101, 3'b000);
            cmp_model();
            if (gnt4 == prev) begin
               run++;
            end else begin
               if (i > 4) chk("hold_run_len", 32'(run), 32'(MH));
               run  = 1;
               prev = gnt4;
            end
         end
      end
      for (int i = 0; i < 10; i++) begin
         cycle(4'b0001, 3'b000);
         chk("solo_hold_gnt", 32'(gnt4), 32'h1);
      end
      cycle(4'b0010, 3'b000);
      chk("handoff_gnt", 32'(gnt4), 32'h2);
`endif
      cmp_model();

      // N=3 wrap behaviour; requester 1 keeps dut4 busy meanwhile.
      cycle(4'b0010, 3'b010);
      chk("n3_a_gnt", 32'(gnt3), 32'h2);
      cycle(4'b0010, 3'b101);
      chk("n3_b_gnt", 32'(gnt3), 32'h4);
      chk("n3_b_id",  32'(id3),  32'd2);
      cycle(4'b0010, 3'b001);
      chk("n3_wrap_gnt", 32'(gnt3), 32'h1);
      chk("n3_wrap_id",  32'(id3),  32'd0);
      cycle(4'b0010, 3'b000);
      chk("n3_idle_busy", 32'(busy3), 32'd0);
      chk("n3_idle_id",   32'(id3),   32'd0);
      cycle(4'b0010, 3'b110);
      chk("n3_c_gnt", 32'(gnt3), 32'h2);
      cmp_model();

      // Asynchronous reset while requester 1 owns dut4.
      chk("pre_rst_gnt4", 32'(gnt4), 32'h2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt4",  32'(gnt4),  32'd0);
      chk("async_rst_busy4", 32'(busy4), 32'd0);
      chk("async_rst_gnt3",  32'(gnt3),  32'd0);
      m4 = mreset(4);
      m3 = mreset(3);
      @(negedge clk);
      req4  = 4'b0010;
      req3  = 3'b101;
      rst_n = 1'b1;
      @(posedge clk);
      m4 = mstep(m4, 4, {28'd0, req4});
      m3 = mstep(m3, 3, {29'd0, req3});
      #1;
      chk("post_rst_gnt4", 32'(gnt4), 32'h2);
      chk("post_rst_gnt3", 32'(gnt3), 32'h1);
      cmp_model();

      // Random traffic with sticky requests against the reference model.
      r4 = req4;
      r3 = req3;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r4[b] = ~r4[b];
         end
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 3) == 0) r3[b] = ~r3[b];
         end
         cycle(r4, r3);
         cmp_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rr_arbiter
